// File: rtl/cpu_program_sequencer.sv
// Program sequencer: feeds instruction/immediate words from a local program memory to the
// multi-cycle CPU core, tracking the CPU step counter with a shadow copy.
module cpu_program_sequencer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [15:0]   load_data_i,
  input  logic [AW:0]   prog_len_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          cpu_done_i,
  output logic          cpu_run_o,
  output logic [15:0]   cpu_din_o,
  output logic          busy_o,
  output logic          finish_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [AW:0]   pc_o,
  output logic [15:0]   instr_count_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAlign = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  localparam logic [2:0] OpMv  = 3'd0;
  localparam logic [2:0] OpMvi = 3'd1;

  localparam logic [AW:0] LenMax = (AW+1)'(DEPTH);

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrIll   = 2'b01;
  localparam logic [1:0] ErrTrunc = 2'b10;
  localparam logic [1:0] ErrDone  = 2'b11;

  logic [15:0] mem_q [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [1:0]  sh_q, sh_d;
  logic [2:0]  op_q, op_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        stop_pend_q, stop_pend_d;
  logic        finish_q, finish_d;

  logic [15:0] word_cur, word_imm;
  logic [AW:0] pc_plus1;
  logic [2:0]  op_cur;
  logic        end_norm, end_ill, end_trunc, bnd_stop;
  logic        run, clear_cond, retire, done_bad;

  // Program memory is intentionally not reset so contents survive across runs.
  always_ff @(posedge clk) begin
    if (load_we_i && (state_q == StIdle)) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  always_comb begin
    pc_plus1   = pc_q + (AW+1)'(1);
    word_cur   = mem_q[pc_q[AW-1:0]];
    word_imm   = mem_q[pc_plus1[AW-1:0]];
    op_cur     = word_cur[8:6];
    end_norm   = (pc_q >= len_q) || stop_pend_q;
    end_ill    = op_cur[2];
    end_trunc  = (op_cur == OpMvi) && (pc_plus1 >= len_q);
    bnd_stop   = (state_q == StRun) && (sh_q == 2'd0) && (end_norm || end_ill || end_trunc);
    run        = (state_q == StRun) && !bnd_stop;
    // Mirrors the CPU's step-counter clear: MV/MVI finish at step 1, ADD/SUB at step 3.
    clear_cond = ((sh_q == 2'd1) && ((op_q == OpMv) || (op_q == OpMvi))) ||
                 ((sh_q == 2'd3) && (op_q[2:1] == 2'b01));
    retire     = run && clear_cond;
    done_bad   = run && (cpu_done_i != clear_cond);
  end

  always_comb begin
    cpu_din_o = 16'h0000;
    if (run && (sh_q == 2'd0)) begin
      cpu_din_o = word_cur;
    end else if (run && (sh_q == 2'd1) && (op_q == OpMvi)) begin
      cpu_din_o = word_imm;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = retire ? 2'd0 : sh_q + 2'd1;
    op_d        = (run && (sh_q == 2'd0)) ? op_cur : op_q;
    pc_d        = pc_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    code_d      = code_q;
    stop_pend_d = stop_pend_q | stop_i;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d       = (prog_len_i > LenMax) ? LenMax : prog_len_i;
          pc_d        = '0;
          cnt_d       = 16'h0000;
          err_d       = 1'b0;
          code_d      = ErrNone;
          stop_pend_d = stop_i;
          state_d     = (sh_q == 2'd3) ? StRun : StAlign;
        end
      end
      StAlign: begin
        if (sh_q == 2'd3) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (bnd_stop) begin
          state_d     = StIdle;
          stop_pend_d = 1'b0;
          if (!end_norm && end_ill) begin
            err_d  = 1'b1;
            code_d = ErrIll;
          end else if (!end_norm && end_trunc) begin
            err_d  = 1'b1;
            code_d = ErrTrunc;
          end
        end else begin
          if (retire) begin
            pc_d  = pc_q + ((op_q == OpMvi) ? (AW+1)'(2) : (AW+1)'(1));
            cnt_d = cnt_q + 16'h0001;
          end
          if (done_bad) begin
            state_d     = StIdle;
            stop_pend_d = 1'b0;
            err_d       = 1'b1;
            code_d      = ErrDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    finish_d = (state_q == StRun) && (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      sh_q        <= 2'd0;
      op_q        <= 3'd0;
      pc_q        <= '0;
      len_q       <= '0;
      cnt_q       <= 16'h0000;
      err_q       <= 1'b0;
      code_q      <= ErrNone;
      stop_pend_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      op_q        <= op_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      code_q      <= code_d;
      stop_pend_q <= stop_pend_d;
      finish_q    <= finish_d;
    end
  end

  assign cpu_run_o     = run;
  assign busy_o        = (state_q != StIdle);
  assign finish_o      = finish_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;
  assign pc_o          = pc_q;
  assign instr_count_o = cnt_q;

endmodule

// File: doc/cpu_program_sequencer.md
# cpu_program_sequencer

Program sequencer that drives the 16-bit multi-cycle CPU core's `run`/`din` inputs from a local program memory. It is loaded over a simple write port and started with a pulse. It then feeds instruction and immediate words to the CPU in lockstep with the CPU's 2-bit step counter, which it mirrors internally. It stops at end of program, on a stop request at an instruction boundary, or on an error.

## Interface
- `DEPTH`, default 32: program memory depth in 16-bit words; power of two, 2..256.
- `AW`, default 5: address width, equal to log2(DEPTH).
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low; shared with the CPU core.
- `load_we`  in  1  program-memory write strobe; ignored while `busy`=1.
- `load_addr`  in  AW  write address.
- `load_data`  in  16  write data.
- `prog_len`  in  AW+1  program length in words; sampled on `start`.
- `start`  in  1  start pulse; honoured only in IDLE.
- `stop`  in  1  stop request; sticky until honoured.
- `cpu_done`  in  1  CPU `done`.
- `cpu_run`  out  1  CPU `run`.
- `cpu_din`  out  16  CPU `din`.
- `busy`  out  1  FSM not in IDLE.
- `finish`  out  1  one-cycle pulse when a run ends, for any reason.
- `err`  out  1  sticky error flag; cleared on the next accepted `start`.
- `err_code`  out  2  01 illegal opcode, 10 truncated MVI, 11 done mismatch; 00 otherwise.
- `pc`  out  AW+1  current word address.
- `instr_count`  out  16  instructions retired in the current run; wraps modulo 2^16.

## Operation
- Memory: DEPTH×16 register array with asynchronous read. It is not reset; contents hold across runs.
- Shadow counter `sh[1:0]`:
  - Reset to 0 by `resetn`.
  - Increments every cycle.
  - Cleared to 0 instead when `cpu_run`=1 and the expected clear condition holds: `sh`=1 with opcode MV/MVI, or `sh`=3 with opcode ADD/SUB.
  - This matches the CPU step counter exactly.
- Opcode register `op_q[2:0]`: loaded from `mem[pc][8:6]` when `cpu_run`=1 and `sh`=0.
- FSM states: IDLE, ALIGN, RUN.
  - IDLE + `start`: latch `prog_len`, set `pc`=0, `instr_count`=0, clear `err`/`err_code`/pending stop. Go to RUN if `sh`=3, else ALIGN.
  - ALIGN: go to RUN when `sh`=3.
  - RUN, cycle with `sh`=0 (boundary check on word `mem[pc]`). Go to IDLE with `cpu_run`=0 in that cycle if:
    - `pc`≥len, or a stop is pending: normal end;
    - opcode 1xx: err 01;
    - opcode MVI and `pc`+1≥len: err 10.
  - Otherwise `cpu_run`=1 and `cpu_din`=`mem[pc]`.
  - RUN, `sh`=1 with `op_q`=MVI: `cpu_din`=`mem[pc+1]`.
  - RUN, other cycles: `cpu_din`=0.
- `cpu_run` = (state==RUN) AND NOT (boundary stop condition). It is combinational from registered state and memory.
- Retire: on a clear edge, `pc` += 2 for MVI, else += 1, and `instr_count` += 1.
- Done check: in every cycle with `cpu_run`=1, the expected done is high exactly on clear cycles. If `cpu_done` differs: err 11, go to IDLE next edge, `finish` pulses.
- `finish`: registered, high the cycle after any transition RUN→IDLE.
- Reset outputs: `cpu_run`=0, `cpu_din`=0, `busy`=0, `finish`=0, `err`=0, `err_code`=00, `pc`=0, `instr_count`=0, FSM in IDLE, `sh`=0.

## Timing
- Start latency: RUN is entered at the edge ending the `sh`=3 cycle, so the first fetch falls 1–4 cycles after `start`.
- Per-instruction cycles with `cpu_run`=1: MV 2, MVI 2, ADD/SUB 4.
- End: the boundary cycle has `cpu_run`=0, and `finish` is high the next cycle.
- `start` while busy: ignored.
- `start` and `stop` in the same cycle: the run starts and stops at its first boundary with `instr_count`=0.
- `stop` mid-instruction: the instruction completes and the run ends at the next boundary.
- `load_we` while busy: no write.
- `prog_len`=0: the first boundary ends the run immediately with no error.
- `prog_len`>DEPTH: saturates to DEPTH.
- `resetn` low mid-run: asynchronous return to IDLE, with all outputs at their reset values.

## Test plan
- Load 0x0040, 0x0005, 0x0048, 0x0003, 0x0081, 0x0010 (MVI r0,#5; MVI r1,#3; ADD r0,r1; MV r2,r0), `prog_len`=6, start while `sh`=3 → `cpu_run` high for exactly 10 cycles, `finish` on cycle 12, `pc`=6, `instr_count`=4, `err`=0.
- Start while `sh`=0 → 3 ALIGN cycles before the first fetch; first fetch `cpu_din`=0x0040.
- Word 0x0100 (opcode 100) at `pc`=0 → `cpu_run` never asserted, `err`=1, `err_code`=01, `finish` pulse, `pc`=0.
- `prog_len`=1 with MVI 0x0040 → `err_code`=10, no run cycles.
- Force `cpu_done`=0 on the MV done cycle → `err_code`=11, `busy` falls the next cycle.
- `stop` asserted during the ADD step-2 cycle → ADD retires and the run ends at the next boundary. Separately, assert `resetn` mid-MVI → all outputs return to reset values immediately.
